// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between two producers in bounded bursts.
// Optional per-producer accepted-word counters are built when FIFO_ARB_STATS_EN is defined.
module fifo_wr_arbiter #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned BURST_MAX  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0,
  input  logic                  req1,
  input  logic [DATA_WIDTH-1:0] data0,
  input  logic [DATA_WIDTH-1:0] data1,
  output logic                  ack0,
  output logic                  ack1,
  input  logic                  fifo_full,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  write,
  output logic [1:0]            grant,
  output logic [15:0]           wr_cnt0,
  output logic [15:0]           wr_cnt1
);

  localparam int unsigned CNT_W      = 8;
  localparam int unsigned STAT_W     = 16;
  localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(BURST_MAX - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_burst_cnt;
  logic [CNT_W-1:0] w_burst_nxt;
  logic             r_last;
  logic             w_last_nxt;

  // State, burst counter and last-served pointer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_burst_cnt <= '0;
      r_last      <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_burst_cnt <= w_burst_nxt;
      r_last      <= w_last_nxt;
    end
  end

  // Next-state decode and combinational write-port mux
  always_comb begin
    w_state_nxt = r_state;
    w_burst_nxt = r_burst_cnt;
    w_last_nxt  = r_last;
    ack0        = 1'b0;
    ack1        = 1'b0;
    write       = 1'b0;
    wr_data     = '0;
    grant       = 2'b00;

    case (r_state)
      IDLE: begin
        if (req0 && req1) begin
          w_state_nxt = r_last ? GRANT0 : GRANT1;
        end else if (req0) begin
          w_state_nxt = GRANT0;
        end else if (req1) begin
          w_state_nxt = GRANT1;
        end
      end
      GRANT0: begin
        grant   = 2'b01;
        wr_data = data0;
        ack0    = req0 & ~fifo_full;
        write   = ack0;
        if (!req0) begin
          w_state_nxt = req1 ? GRANT1 : IDLE;
        end else if (ack0 && (r_burst_cnt == BURST_LAST) && req1) begin
          w_state_nxt = GRANT1;
        end
        if (ack0 && (r_burst_cnt != BURST_LAST)) begin
          w_burst_nxt = r_burst_cnt + CNT_W'(1);
        end
      end
      GRANT1: begin
        grant   = 2'b10;
        wr_data = data1;
        ack1    = req1 & ~fifo_full;
        write   = ack1;
        if (!req1) begin
          w_state_nxt = req0 ? GRANT0 : IDLE;
        end else if (ack1 && (r_burst_cnt == BURST_LAST) && req0) begin
          w_state_nxt = GRANT0;
        end
        if (ack1 && (r_burst_cnt != BURST_LAST)) begin
          w_burst_nxt = r_burst_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase

    // Leaving a grant restarts the burst and remembers who was just served
    if (w_state_nxt != r_state) begin
      w_burst_nxt = '0;
      if (r_state == GRANT0) begin
        w_last_nxt = 1'b0;
      end else if (r_state == GRANT1) begin
        w_last_nxt = 1'b1;
      end
    end
  end

`ifdef FIFO_ARB_STATS_EN
  logic [STAT_W-1:0] r_wr_cnt0;
  logic [STAT_W-1:0] r_wr_cnt1;

  // Saturating accepted-word counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_cnt0 <= '0;
      r_wr_cnt1 <= '0;
    end else begin
      if (ack0 && (r_wr_cnt0 != {STAT_W{1'b1}})) begin
        r_wr_cnt0 <= r_wr_cnt0 + STAT_W'(1);
      end
      if (ack1 && (r_wr_cnt1 != {STAT_W{1'b1}})) begin
        r_wr_cnt1 <= r_wr_cnt1 + STAT_W'(1);
      end
    end
  end

  assign wr_cnt0 = r_wr_cnt0;
  assign wr_cnt1 = r_wr_cnt1;
`else
  assign wr_cnt0 = '0;
  assign wr_cnt1 = '0;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: expected writes are queued as stimulus is
// driven and popped whenever the arbiter asserts write.
module tb_fifo_wr_arbiter;

  localparam int unsigned DW = 8;

  logic          clk;
  logic          reset;
  logic          req0;
  logic          req1;
  logic [DW-1:0] data0;
  logic [DW-1:0] data1;
  logic          ack0;
  logic          ack1;
  logic          fifo_full;
  logic [DW-1:0] wr_data;
  logic          write;
  logic [1:0]    grant;
  logic [15:0]   wr_cnt0;
  logic [15:0]   wr_cnt1;

  int            n_checks;
  int            n_errors;
  int            n_exp0;
  int            n_exp1;
  bit            mon_en;
  logic [8:0]    sb[$];
  logic [8:0]    sb_exp;

  fifo_wr_arbiter #(.DATA_WIDTH(DW), .BURST_MAX(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .req0      (req0),
    .req1      (req1),
    .data0     (data0),
    .data1     (data1),
    .ack0      (ack0),
    .ack1      (ack1),
    .fifo_full (fifo_full),
    .wr_data   (wr_data),
    .write     (write),
    .grant     (grant),
    .wr_cnt0   (wr_cnt0),
    .wr_cnt1   (wr_cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push(input bit prod, input logic [7:0] d, input int n);
    for (int i = 0; i < n; i++) sb.push_back({prod, d});
    if (prod) n_exp1 += n;
    else      n_exp0 += n;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Write monitor: every written word must match the head of the scoreboard
  always @(negedge clk) begin
    if (mon_en) begin
      if (write) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", 32'(sb.size()), 32'd1);
        end else begin
          sb_exp = sb.pop_front();
          chk("wr_data", 32'(wr_data), 32'(sb_exp[7:0]));
          chk("ack_owner", 32'({ack1, ack0}), sb_exp[8] ? 32'd2 : 32'd1);
        end
      end else begin
        chk("ack_idle", 32'({ack1, ack0}), 32'd0);
      end
    end
  end

  initial begin
    n_checks = 0; n_errors = 0; n_exp0 = 0; n_exp1 = 0; mon_en = 1'b0;
    reset = 1'b1; req0 = 1'b0; req1 = 1'b0; fifo_full = 1'b0;
    data0 = 8'hA0; data1 = 8'hB1;
    #1;
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_write", 32'(write), 32'd0);
    chk("rst_wr_data", 32'(wr_data), 32'd0);
    chk("rst_cnt0", 32'(wr_cnt0), 32'd0);
    chk("rst_cnt1", 32'(wr_cnt1), 32'd0);
    #1; reset = 1'b0; req0 = 1'b1; req1 = 1'b1;
    #10; reset = 1'b1;
    #2;
    chk("midrst_grant", 32'(grant), 32'd0);
    chk("midrst_write", 32'(write), 32'd0);
    chk("midrst_acks", 32'({ack1, ack0}), 32'd0);
    #3; reset = 1'b0;

    // Both producers saturating: A0x4, B1x4, A0x4 with no gaps
    mon_en = 1'b1;
    push(1'b0, 8'hA0, 4); push(1'b1, 8'hB1, 4); push(1'b0, 8'hA0, 4);
    tick(1);
    chk("first_grant", 32'(grant), 32'd1);
    chk("first_write", 32'(write), 32'd1);
    tick(4); chk("rot_to_1", 32'(grant), 32'd2);
    tick(4); chk("rot_to_0", 32'(grant), 32'd1);
    tick(4); req0 = 1'b0; req1 = 1'b0;
    tick(1); chk("idle_after_drop", 32'(grant), 32'd0);

    // Lone producer 0, data 47, no burst limit applied
    data0 = 8'h47; req0 = 1'b1; push(1'b0, 8'h47, 6);
    tick(1);
    chk("lone_grant", 32'(grant), 32'd1);
    chk("lone_data", 32'(wr_data), 32'h47);
    tick(5); chk("lone_no_rotate", 32'(grant), 32'd1);
    tick(1); req0 = 1'b0;
    tick(1); chk("lone_idle", 32'(grant), 32'd0);

    // last=0 now: producer 1 wins, drops after 2 words, producer 0 follows at once
    data0 = 8'hA0; req0 = 1'b1; req1 = 1'b1; push(1'b1, 8'hB1, 2);
    tick(1); chk("tie_to_1", 32'(grant), 32'd2);
    tick(2); req1 = 1'b0; push(1'b0, 8'hA0, 4);
    tick(1);
    chk("drop_switch", 32'(grant), 32'd1);
    chk("drop_write", 32'(write), 32'd1);
    req1 = 1'b1;

    // FIFO full for 3 cycles after 2nd word of producer-0 burst
    tick(2); fifo_full = 1'b1;
    tick(1);
    chk("full_grant", 32'(grant), 32'd1);
    chk("full_write", 32'(write), 32'd0);
    tick(2); fifo_full = 1'b0;
    chk("full_hold", 32'(grant), 32'd1);
    push(1'b1, 8'hB1, 4); push(1'b0, 8'hA0, 1);
    tick(2); chk("full_then_rot", 32'(grant), 32'd2);
    tick(4); req1 = 1'b0;
    tick(1); req0 = 1'b0;
    tick(1); chk("end_idle", 32'(grant), 32'd0);

`ifdef FIFO_ARB_STATS_EN
    chk("cnt0_total", 32'(wr_cnt0), 32'(n_exp0));
    chk("cnt1_total", 32'(wr_cnt1), 32'(n_exp1));
`else
    chk("cnt0_off", 32'(wr_cnt0), 32'(n_exp0 * 0));
    chk("cnt1_off", 32'(wr_cnt1), 32'(n_exp1 * 0));
`endif

    // Reset clears counters; then 10 words from producer 0 and 3 from producer 1
    reset = 1'b1;
    #1;
    chk("rst2_grant", 32'(grant), 32'd0);
    chk("rst2_cnt0", 32'(wr_cnt0), 32'd0);
    chk("rst2_cnt1", 32'(wr_cnt1), 32'd0);
    n_exp0 = 0; n_exp1 = 0;
    #1; reset = 1'b0; req0 = 1'b1; push(1'b0, 8'hA0, 10);
    tick(1); chk("stat_grant0", 32'(grant), 32'd1);
    tick(10); req0 = 1'b0; req1 = 1'b1; push(1'b1, 8'hB1, 3);
    tick(1); chk("stat_grant1", 32'(grant), 32'd2);
    tick(3); req1 = 1'b0;
    tick(1);
    chk("stat_idle", 32'(grant), 32'd0);
`ifdef FIFO_ARB_STATS_EN
    chk("stat_cnt0", 32'(wr_cnt0), 32'd10);
    chk("stat_cnt1", 32'(wr_cnt1), 32'd3);
`else
    chk("stat_cnt0", 32'(wr_cnt0), 32'd0);
    chk("stat_cnt1", 32'(wr_cnt1), 32'd0);
`endif
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-port arbiter that shares the single write port of the 8-bit `fifo` between two producers. It grants one producer at a time in bounded bursts, forwards the granted producer's word onto `wr_data`/`write`, and stalls every producer while the FIFO reports `Full`. It sits directly in front of the FIFO's write side; the read side is untouched.

## Interface

Parameters:
- `DATA_WIDTH`, 8: width of producer data and FIFO write data.
- `BURST_MAX`, 4: maximum consecutive words accepted from one producer before rotating, if the other producer is requesting. Legal range 1–255.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req0` / `req1`  in  1  producer N has a valid word on `dataN`.
- `data0` / `data1`  in  DATA_WIDTH  producer N write data; held stable while `reqN` is high and `ackN` is low.
- `ack0` / `ack1`  out  1  combinational; high in the cycle producer N's word is written.
- `fifo_full`  in  1  connected to FIFO `Full`.
- `wr_data`  out  DATA_WIDTH  connected to FIFO `wr_data`.
- `write`  out  1  connected to FIFO `write`.
- `grant`  out  2  one-hot current owner: 01 = producer 0, 10 = producer 1, 00 = idle.
- `wr_cnt0` / `wr_cnt1`  out  16  words accepted per producer (see Configuration).

## Operation

- States: IDLE, GRANT0, GRANT1. `grant` decodes the state directly.
- Pointer `last` records the producer served most recently. Reset value is 1, so producer 0 wins the first tie.
- IDLE:
  - No writes.
  - If both producers request, go to GRANT[!last]; if only one requests, go to that GRANT; otherwise stay in IDLE.
- GRANTn:
  - `ackN = write = reqN & ~fifo_full`; `wr_data = dataN` (combinational mux).
  - The non-granted ack is 0.
  - `burst_cnt` (8-bit) increments on every ack.
- Transitions out of GRANTn, evaluated at the clock edge in this priority order:
  1. `~reqN`: if the other producer requests, go to GRANT[other]; otherwise go to IDLE.
  2. `ackN` with `burst_cnt == BURST_MAX-1` and the other producer requesting: go to GRANT[other].
  3. Otherwise stay in GRANTn.
- Any change of state loads `burst_cnt` with 0 and sets `last = n`.
- `fifo_full` high in GRANTn:
  - No ack and no write.
  - `burst_cnt` is frozen; there is no rotation caused by full alone.
  - The state is held unless `reqN` drops.
- If the other producer is idle, the burst limit is ignored and `burst_cnt` saturates at `BURST_MAX-1`.
- Producer protocol: a producer may update `dataN` or drop `reqN` only in the cycle after `ackN`. A word that is never acked is never written.

## Timing

- Reset values: state IDLE, `grant`=00, `ack0`=`ack1`=`write`=0, `wr_data`=0, `burst_cnt`=0, `last`=1, `wr_cnt0`=`wr_cnt1`=0.
- Grant latency: a request that arrives while IDLE is written no earlier than the cycle after it is first sampled.
- Throughput: one word per cycle while granted and not full.
- Switch between producers: zero idle cycles. A rotation at the burst limit writes from the new owner in the very next cycle.
- `fifo_full` is registered in the FIFO, so there is no combinational loop through `write`. A write that fills the FIFO is followed by `fifo_full`=1 on the next cycle, which blocks further writes.
- Reset mid-burst: immediate return to IDLE. The word in flight is not written if `reset` is high at the edge. Producers keep their requests and are re-arbitrated from `last`=1.

## Configuration

- `FIFO_ARB_STATS_EN` defined:
  - `wr_cnt0` and `wr_cnt1` count accepted words per producer.
  - Each counter is 16 bits, saturating at 16'hFFFF.
  - Both counters clear on reset.
- `FIFO_ARB_STATS_EN` undefined: the counters are not built and both ports are tied to 0.

## Test plan

- Assert `reset` at 12 ns for 5 ns with both producers requesting -> `grant`=00, `write`=0, `ack0`=`ack1`=0 during reset; first write is from producer 0 after reset releases.
- `req0`=1 with `data0`=8'h47 held and FIFO never full -> `grant`=01 one cycle later; then `write`=`ack0`=1 and `wr_data`=8'h47 every cycle.
- Both producers continuously requesting, `BURST_MAX`=4, `data0`=8'hA0, `data1`=8'hB1 -> write pattern A0×4, B1×4, A0×4, … with no gap cycles.
- `fifo_full` forced high for 3 cycles after the 2nd word of a producer-0 burst, with both requesting -> 3 cycles with `write`=0 and `grant`=01 held; then 2 more A0 words before rotating to producer 1.
- Producer 1 drops `req1` after 2 acked words while `req0`=1 -> `grant`=01 in the next cycle and producer 0 is written immediately.
- With `FIFO_ARB_STATS_EN` defined, 10 words accepted from producer 0 and 3 from producer 1 -> `wr_cnt0`=10 and `wr_cnt1`=3. Without the macro, both read 0.
